// File: rtl/cache_dm_refill.sv
// cache_dm_refill: direct-mapped read-only word cache with
// line refill from a req/ack backing memory.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid/addr CPU read request (word address)
//   req_ready      request accepted (high only in IDLE)
//   resp_valid     one-cycle response pulse
//   resp_data      response word (holds between pulses)
//   resp_hit       1 = hit, 0 = served after refill
//   flush          invalidate all lines
//   mem_req/addr   backing-memory read request
//   mem_ack/rdata  memory returns a word this cycle
// Optional (macro CACHE_DM_STATS_EN):
//   hit_count, miss_count  saturating 32-bit event counters
module cache_dm_refill #(
  parameter int WIDTH          = 32,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_hit,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
`ifdef CACHE_DM_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int DEPTH = NUM_LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESPOND
  } state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [OFF_W-1:0]     cnt_q;
  logic [OFF_W-1:0]     cnt_d;
  logic [NUM_LINES-1:0] valid_q;
  logic                 flush_pend_q;
  logic                 resp_valid_q;
  logic                 resp_hit_q;
  logic [WIDTH-1:0]     resp_data_q;
  logic                 mem_req_q;
  logic [ADDR_W-1:0]    mem_addr_q;

  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [WIDTH-1:0]     data_q [DEPTH];

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-1:0]     req_off;
  logic [TAG_W-1:0]     a_tag;
  logic [IDX_W-1:0]     a_idx;
  logic [OFF_W-1:0]     a_off;

  logic                 accept;
  logic                 lookup_hit;
  logic                 ack_fire;
  logic                 last_word;
  logic [WIDTH-1:0]     hit_word;
  logic [WIDTH-1:0]     fill_word;

  assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_off = req_addr[OFF_W-1:0];
  assign a_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign a_idx   = addr_q[OFF_W +: IDX_W];
  assign a_off   = addr_q[OFF_W-1:0];

  assign accept     = req_valid && (state_q == IDLE);
  assign lookup_hit = valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag);
  assign ack_fire   = (state_q == REFILL) &&
                      mem_req_q && mem_ack;
  assign last_word  = &cnt_q;
  assign cnt_d      = cnt_q + OFF_W'(1);
  assign hit_word   = data_q[{req_idx, req_off}];
  // The last word is still on the bus when the
  // response is latched, so bypass the array for it.
  assign fill_word  = (a_off == cnt_q) ? mem_rdata
                      : data_q[{a_idx, a_off}];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Lookup above uses the pre-flush valid bits.
          if (flush || flush_pend_q) valid_q <= '0;
          flush_pend_q <= 1'b0;
          if (accept) begin
            addr_q <= req_addr;
            if (lookup_hit) begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b1;
              resp_data_q  <= hit_word;
            end else begin
              valid_q[req_idx] <= 1'b0;
              cnt_q      <= '0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {req_tag, req_idx,
                             {OFF_W{1'b0}}};
              state_q    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (ack_fire) begin
            cnt_q <= cnt_d;
            if (last_word) begin
              mem_req_q      <= 1'b0;
              valid_q[a_idx] <= 1'b1;
              resp_valid_q   <= 1'b1;
              resp_hit_q     <= 1'b0;
              resp_data_q    <= fill_word;
              state_q        <= RESPOND;
            end else begin
              mem_addr_q <= {a_tag, a_idx, cnt_d};
            end
          end
        end
        RESPOND: begin
          if (flush) flush_pend_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && ack_fire) begin
      data_q[{a_idx, cnt_q}] <= mem_rdata;
      if (last_word) tag_q[a_idx] <= a_tag;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

`ifdef CACHE_DM_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (lookup_hit && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (!lookup_hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_dm_refill.sv
// tb_cache_dm_refill: directed bench for cache_dm_refill
// with a response/refill scoreboard model.
module tb_cache_dm_refill;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = '0;
  logic        flush = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic        mem_req;
  logic [7:0]  mem_addr;
`ifdef CACHE_DM_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_dm_refill dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_hit  (resp_hit),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef CACHE_DM_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          cyc;
  } obs_t;

  exp_t       exp_q[$];
  obs_t       obs_q[$];
  exp_t       ce;
  bit         mvalid[4];
  logic [3:0] mtag[4];
  bit         pend = 1'b0;
  bit         miss_active = 1'b0;
  bit         started = 1'b0;
  int         miss_start = 0;
  int         miss_due = -1;
  int         acks_seen = 0;
  logic [7:0] exp_base = '0;
  int         n_hit = 0;
  int         n_miss = 0;

  function automatic logic [31:0] mem_fn(input logic [7:0] a);
    return {24'h0, a} + 32'h7C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, want);
    end
  endtask

  // Compare process: scoreboard of responses, refill
  // address sequence, ready and mem_req expectations.
  always @(negedge clk) begin
    if (started && !rst) begin
      bit         em;
      logic [7:0] ea;
      em = miss_active && cyc >= miss_start &&
           acks_seen < WPL;
      chk("req_ready", 32'(req_ready),
          32'(!(miss_active && cyc >= miss_start)));
      chk("mem_req", 32'(mem_req), 32'(em));
      if (mem_req && em) begin
        ea = exp_base + 8'(acks_seen);
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (mem_ack) acks_seen++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected got %h want none",
                   resp_data);
        end else begin
          ce = exp_q.pop_front();
          chk("resp_data", resp_data, ce.data);
          chk("resp_hit", 32'(resp_hit), 32'(ce.hit));
          chk("resp_cycle", cyc, ce.hit ? ce.due : miss_due);
          obs_q.push_back('{resp_data, resp_hit, cyc});
          if (!ce.hit) begin
            miss_active = 1'b0;
            if (pend) begin
              mvalid = '{default: 1'b0};
              pend = 1'b0;
            end
          end
        end
      end else if (exp_q.size() > 0) begin
        int d;
        d = exp_q[0].hit ? exp_q[0].due : miss_due;
        if (d >= 0 && cyc > d) begin
          checks++;
          errors++;
          $display("FAIL resp_missing got none want %h at %0d",
                   exp_q[0].data, d);
          ce = exp_q.pop_front();
          if (!ce.hit) miss_active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic access(input logic [7:0] a, input int stall,
                        input int nacks, input bit fl);
    int t;
    bit h;
    t = 0;
    while (!req_ready && t < 50) begin
      tick();
      t++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout got 0 want 1");
      return;
    end
    h = mvalid[a[3:2]] && (mtag[a[3:2]] == a[7:4]);
    req_valid = 1'b1;
    req_addr  = a;
    if (h) begin
      exp_q.push_back('{mem_fn(a), 1'b1, cyc + 1});
      n_hit++;
    end else begin
      exp_q.push_back('{mem_fn(a), 1'b0, -1});
      n_miss++;
      mvalid[a[3:2]] = 1'b1;
      mtag[a[3:2]]   = a[7:4];
      exp_base    = {a[7:2], 2'b00};
      acks_seen   = 0;
      miss_due    = -1;
      miss_start  = cyc + 1;
      miss_active = 1'b1;
    end
    tick();
    req_valid = 1'b0;
    if (!h) begin
      for (int w = 0; w < nacks; w++) begin
        repeat (stall) tick();
        mem_ack   = 1'b1;
        mem_rdata = mem_fn(exp_base + 8'(w));
        if (fl && w == 1) begin
          flush = 1'b1;
          pend  = 1'b1;
        end
        if (w == WPL - 1) miss_due = cyc + 1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        flush     = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d want 0",
               exp_q.size());
    end
    tick();
  endtask

  task automatic lit(input string nm, input logic [31:0] d,
                     input bit h);
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got no response want %h", nm, d);
    end else begin
      chk(nm, obs_q[$].data, d);
      chk({nm, "_hit"}, 32'(obs_q[$].hit), 32'(h));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    mvalid = '{default: 1'b0};
    mtag   = '{default: 4'h0};
    rst = 1'b1;
    idle(3);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
`ifdef CACHE_DM_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    rst = 1'b0;
    started = 1'b1;

    // Cold miss.
    access(8'h25, 0, WPL, 1'b0);
    drain();
    lit("cold_miss", 32'hA1, 1'b0);

    // Back-to-back hits.
    access(8'h24, 0, WPL, 1'b0);
    access(8'h27, 0, WPL, 1'b0);
    access(8'h26, 0, WPL, 1'b0);
    drain();
    n = obs_q.size();
    chk("hit0", obs_q[n-3].data, 32'hA0);
    chk("hit1", obs_q[n-2].data, 32'hA3);
    chk("hit2", obs_q[n-1].data, 32'hA2);
    chk("hit_b2b", 32'(obs_q[n-1].cyc - obs_q[n-3].cyc), 32'd2);

    // Conflict eviction.
    access(8'h65, 0, WPL, 1'b0);
    drain();
    lit("evict_fill", 32'hE1, 1'b0);
    access(8'h25, 0, WPL, 1'b0);
    drain();
    lit("evict_remiss", 32'hA1, 1'b0);
    access(8'h25, 0, WPL, 1'b0);
    drain();
    lit("evict_rehit", 32'hA1, 1'b1);

    // Stalled memory.
    access(8'h34, 5, WPL, 1'b0);
    drain();
    lit("stall_fill", 32'hB0, 1'b0);

    // Flush in IDLE.
    flush = 1'b1;
    mvalid = '{default: 1'b0};
    tick();
    flush = 1'b0;
    access(8'h25, 0, WPL, 1'b0);
    drain();
    lit("flush_idle", 32'hA1, 1'b0);

    // Flush during refill.
    access(8'h48, 0, WPL, 1'b1);
    drain();
    idle(3);
    access(8'h48, 0, WPL, 1'b0);
    drain();
    lit("flush_refill", 32'hC4, 1'b0);

    // Reset in the middle of a refill.
    access(8'h18, 0, 2, 1'b0);
    rst = 1'b1;
    mvalid = '{default: 1'b0};
    exp_q.delete();
    miss_active = 1'b0;
    pend = 1'b0;
    n_hit = 0;
    n_miss = 0;
    tick();
    rst = 1'b0;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
`ifdef CACHE_DM_STATS_EN
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_miss_count", miss_count, 32'd0);
`endif
    access(8'h25, 0, WPL, 1'b0);
    drain();
    lit("post_rst", 32'hA1, 1'b0);
    access(8'h18, 0, WPL, 1'b0);
    drain();
    lit("post_rst_partial", 32'h94, 1'b0);
    access(8'h1B, 0, WPL, 1'b0);
    drain();
    lit("post_rst_hit", 32'h97, 1'b1);

`ifdef CACHE_DM_STATS_EN
    chk("hit_count", hit_count, 32'(n_hit));
    chk("miss_count", miss_count, 32'(n_miss));
`endif
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
